flex_crc_unit: RTL and testbench
================================

FLEX_CRC_UNIT -- requirements
Module: flex_crc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16: CRC register width, legal range 3..32.
REQ-002 SHALL have parameter POLY, default 16'h8005: generator polynomial, x^WIDTH term implicit.
REQ-003 SHALL have parameter INIT, default all ones: register value after reset or clear.
REQ-004 SHALL have parameter RESIDUE, default 16'h800D: good-packet remainder for check mode.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port clear, input, 1: synchronous reload of INIT and return to IDLE.
REQ-008 SHALL have port data_valid, input, 1: data_in carries one serial message bit this cycle.
REQ-009 SHALL have port data_in, input, 1: serial message bit.
REQ-010 SHALL have port append, input, 1: one-cycle pulse that starts shift-out of the complemented CRC.
REQ-011 SHALL have port crc_out, output, WIDTH: current register contents.
REQ-012 SHALL have port serial_out, output, 1: shift-out bit.
REQ-013 SHALL have port serial_valid, output, 1: serial_out is valid this cycle.
REQ-014 SHALL have port busy, output, 1: high while in SHIFT_OUT.
REQ-015 SHALL have port crc_ok, output, 1: register equals RESIDUE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse when shift-out completes.

Function
REQ-017 SHALL implement states IDLE, ACCUM and SHIFT_OUT, plus a bit counter of clog2(WIDTH+1) bits.
REQ-018 In IDLE or ACCUM with data_valid=1, SHALL compute fb = crc[WIDTH-1]^data_in and load crc <= {crc[WIDTH-2:0],0} ^ (fb ? POLY : 0); next state ACCUM.
REQ-019 With data_valid=0 in IDLE/ACCUM, SHALL hold the register and state.
REQ-020 On append in IDLE/ACCUM, SHALL enter SHIFT_OUT next cycle with counter=WIDTH; append in IDLE shifts out ~INIT.
REQ-021 In SHIFT_OUT, SHALL drive serial_out=~crc[WIDTH-1] and serial_valid=1 each cycle, then shift crc left with 0 fill and decrement the counter: exactly WIDTH cycles, MSB first.
REQ-022 On the cycle after the last shift-out bit, SHALL pulse done=1 for one cycle, load INIT and enter IDLE.
REQ-023 data_valid and append SHALL be ignored in SHIFT_OUT.
REQ-024 Priority SHALL be clear > append > data_valid when asserted in the same cycle; append with data_valid does not fold in the bit.
REQ-025 clear in SHIFT_OUT SHALL abort: serial_valid=0 next cycle, no done pulse, crc=INIT, state IDLE.
REQ-026 crc_ok SHALL be combinational (crc_out==RESIDUE) and forced 0 in SHIFT_OUT.
REQ-027 busy SHALL be 1 exactly in SHIFT_OUT; serial_out SHALL be 0 whenever serial_valid=0.

Reset
REQ-028 reset=1 SHALL immediately, without a clock edge, force crc=INIT, state IDLE, counter 0, serial_out/serial_valid/busy/done=0; crc_ok then reflects INIT==RESIDUE.
REQ-029 reset asserted mid-shift-out SHALL abort with no done pulse; operation resumes on the first edge after deassertion.

Verification (WIDTH=5, POLY=5'h05, INIT=5'h1F, RESIDUE=5'h0C)
REQ-030 Reset then one bit 0 -> crc_out=5'h1B; after reset, one bit 1 -> crc_out=5'h1E.
REQ-031 From 5'h1E, append -> serial_out 0,0,0,0,1 on five consecutive cycles with serial_valid=1, busy=1, then done pulse and crc_out=5'h1F.
REQ-032 Feed bits 1,0,0,0,0,1 -> crc_out=5'h0C, crc_ok=1.
REQ-033 clear with data_valid and append in the same cycle -> crc_out=5'h1F, IDLE, no shift-out.
REQ-034 reset pulse on the third shift-out cycle -> outputs 0 asynchronously, no done pulse, crc_out=5'h1F.
REQ-035 data_valid toggled during SHIFT_OUT -> shifted bit sequence unchanged from REQ-031.

Source files
------------

// File: rtl/flex_crc_unit.sv
// Bit-serial CRC generator/checker with parameterized polynomial.
// Accumulates message bits MSB-first, then shifts out the complemented remainder.
module flex_crc_unit #(
  parameter int                 WIDTH   = 16,
  parameter logic [WIDTH-1:0]   POLY    = 16'h8005,
  parameter logic [WIDTH-1:0]   INIT    = '1,
  parameter logic [WIDTH-1:0]   RESIDUE = 16'h800D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             data_valid,
  input  logic             data_in,
  input  logic             append,
  output logic [WIDTH-1:0] crc_out,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             crc_ok,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, SHIFT_OUT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] crc_q;
  logic [WIDTH-1:0] crc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             fb;

  // One LFSR step folding in the current serial bit.
  assign fb    = crc_q[WIDTH-1] ^ data_in;
  assign crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        crc_q   <= INIT;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE, ACCUM: begin
            if (append) begin
              state_q <= SHIFT_OUT;
              cnt_q   <= CNT_W'(WIDTH);
            end else if (data_valid) begin
              state_q <= ACCUM;
              crc_q   <= crc_d;
            end
          end
          SHIFT_OUT: begin
            // Last bit leaves this cycle: reload and flag completion next cycle.
            if (cnt_q == CNT_W'(1)) begin
              state_q <= IDLE;
              crc_q   <= INIT;
              cnt_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              crc_q <= {crc_q[WIDTH-2:0], 1'b0};
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            crc_q   <= INIT;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign busy         = (state_q == SHIFT_OUT);
  assign serial_valid = busy;
  assign serial_out   = busy & ~crc_q[WIDTH-1];
  assign crc_ok       = !busy && (crc_q == RESIDUE);
  assign crc_out      = crc_q;
  assign done         = done_q;

endmodule

// File: tb/tb_flex_crc_unit.sv
// Directed bench for flex_crc_unit at WIDTH=5, POLY=5'h05, INIT=5'h1F, RESIDUE=5'h0C.
module tb_flex_crc_unit;

  logic       clk = 1'b0;
  logic       reset, clear, data_valid, data_in, append;
  logic [4:0] crc_out;
  logic       serial_out, serial_valid, busy, crc_ok, done;
  int         n_cmp = 0;
  int         n_err = 0;

  flex_crc_unit #(.WIDTH(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUE(5'h0C)) dut (
    .clk(clk), .reset(reset), .clear(clear), .data_valid(data_valid),
    .data_in(data_in), .append(append), .crc_out(crc_out),
    .serial_out(serial_out), .serial_valid(serial_valid), .busy(busy),
    .crc_ok(crc_ok), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; data_valid = 1'b0; data_in = 1'b0; append = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic feed(input logic b);
    data_valid = 1'b1; data_in = b;
    step();
    data_valid = 1'b0; data_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (crc_out !== 5'h1F) begin n_err++; $display("FAIL reset_crc got %h exp 1f", crc_out); end
    n_cmp++; if ({busy, serial_valid, serial_out, done} !== 4'b0000) begin n_err++;
      $display("FAIL reset_outs got %b exp 0000", {busy, serial_valid, serial_out, done}); end
    n_cmp++; if (crc_ok !== 1'b0) begin n_err++; $display("FAIL reset_crc_ok got %b exp 0", crc_ok); end
  endtask

  task automatic test_accum();
    do_reset();
    feed(1'b0);
    n_cmp++; if (crc_out !== 5'h1B) begin n_err++; $display("FAIL bit0 got %h exp 1b", crc_out); end
    step(); step();
    n_cmp++; if (crc_out !== 5'h1B) begin n_err++; $display("FAIL hold got %h exp 1b", crc_out); end
    do_reset();
    feed(1'b1);
    n_cmp++; if (crc_out !== 5'h1E) begin n_err++; $display("FAIL bit1 got %h exp 1e", crc_out); end
  endtask

  task automatic test_residue();
    logic [5:0] bits;
    bits = 6'b100001;
    do_reset();
    for (int i = 5; i >= 0; i--) feed(bits[i]);
    n_cmp++; if (crc_out !== 5'h0C) begin n_err++; $display("FAIL residue_crc got %h exp 0c", crc_out); end
    n_cmp++; if (crc_ok !== 1'b1) begin n_err++; $display("FAIL residue_ok got %b exp 1", crc_ok); end
  endtask

  // Starts from 1E and shifts out; toggle_dv stirs data_valid/append mid-shift,
  // with_dv asserts data_valid alongside append.
  task automatic run_shift(input string name, input logic toggle_dv, input logic with_dv,
                           input logic from_idle);
    logic [4:0] exp;
    do_reset();
    if (!from_idle) feed(1'b1);
    exp = from_idle ? 5'b00000 : 5'b00001;
    append = 1'b1; data_valid = with_dv; data_in = 1'b0;
    step();
    append = 1'b0; data_valid = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (toggle_dv) begin data_valid = i[0]; data_in = ~i[1]; append = (i == 2); end
      n_cmp++; if ({serial_valid, busy, serial_out} !== {2'b11, exp[i]}) begin n_err++;
        $display("FAIL %s bit%0d got sv/busy/so=%b exp %b", name, i, {serial_valid, busy, serial_out}, {2'b11, exp[i]}); end
      n_cmp++; if ({crc_ok, done} !== 2'b00) begin n_err++;
        $display("FAIL %s ok_done%0d got %b exp 00", name, i, {crc_ok, done}); end
      #3;
      step();
    end
    data_valid = 1'b0; append = 1'b0;
    n_cmp++; if ({done, busy, serial_valid, serial_out} !== 4'b1000) begin n_err++;
      $display("FAIL %s done_cyc got %b exp 1000", name, {done, busy, serial_valid, serial_out}); end
    n_cmp++; if (crc_out !== 5'h1F) begin n_err++; $display("FAIL %s final_crc got %h exp 1f", name, crc_out); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL %s done_width got %b exp 0", name, done); end
  endtask

  task automatic test_priority();
    do_reset();
    feed(1'b1);
    clear = 1'b1; data_valid = 1'b1; data_in = 1'b1; append = 1'b1;
    step();
    clear = 1'b0; data_valid = 1'b0; append = 1'b0;
    n_cmp++; if (crc_out !== 5'h1F) begin n_err++; $display("FAIL prio_crc got %h exp 1f", crc_out); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if ({busy, serial_valid, done} !== 3'b000) begin n_err++;
        $display("FAIL prio_idle%0d got %b exp 000", i, {busy, serial_valid, done}); end
      step();
    end
  endtask

  task automatic test_reset_midshift();
    do_reset();
    feed(1'b1);
    append = 1'b1; step(); append = 1'b0;
    step(); step();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre got %b exp 1", busy); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({busy, serial_valid, serial_out, done} !== 4'b0000) begin n_err++;
      $display("FAIL rst_mid_async got %b exp 0000", {busy, serial_valid, serial_out, done}); end
    n_cmp++; if (crc_out !== 5'h1F) begin n_err++; $display("FAIL rst_mid_crc got %h exp 1f", crc_out); end
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL rst_mid_after%0d got %b exp 00", i, {busy, done}); end
      step();
    end
    feed(1'b0);
    n_cmp++; if (crc_out !== 5'h1B) begin n_err++; $display("FAIL rst_mid_resume got %h exp 1b", crc_out); end
  endtask

  task automatic test_clear_midshift();
    do_reset();
    feed(1'b1);
    append = 1'b1; step(); append = 1'b0;
    step();
    clear = 1'b1; step(); clear = 1'b0;
    n_cmp++; if ({serial_valid, busy, serial_out} !== 3'b000) begin n_err++;
      $display("FAIL clr_mid got %b exp 000", {serial_valid, busy, serial_out}); end
    n_cmp++; if (crc_out !== 5'h1F) begin n_err++; $display("FAIL clr_mid_crc got %h exp 1f", crc_out); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL clr_mid_done%0d got %b exp 0", i, done); end
      step();
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; data_valid = 1'b0; data_in = 1'b0; append = 1'b0;
    #2;
    test_reset();
    test_accum();
    test_residue();
    run_shift("shift", 1'b0, 1'b0, 1'b0);
    run_shift("shift_dv_toggle", 1'b1, 1'b0, 1'b0);
    run_shift("append_with_dv", 1'b0, 1'b1, 1'b0);
    run_shift("idle_append", 1'b0, 1'b0, 1'b1);
    test_priority();
    test_reset_midshift();
    test_clear_midshift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
